race_progress_tracker: RTL

RACE_PROGRESS_TRACKER -- requirements
Module: race_progress_tracker

---
 rtl/race_progress_tracker.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/race_progress_tracker.sv
// race_progress_tracker
// Per-car distance accumulation for a video-frame-paced race, with sticky
// finish flags, a race FSM and a leader index. Channel 0 is the player.
// Optional feature: define RACE_PROGRESS_CP_EN to add one-cycle checkpoint
// pulses every CP_STEP distance units. Without it the checkpoint port and
// its logic are absent.
module race_progress_tracker #(
    parameter int NUM_CH    = 2,
    parameter int SPEED_W   = 10,
    parameter int FRAC_BITS = 5,
    parameter int DIST_W    = 20,
    parameter int TRACK_LEN = 51200,
    parameter int CP_STEP   = 12800
) (
    input  logic                                       clk,
    input  logic                                       resetN,
    input  logic                                       startOfFrame,
    input  logic                                       race_start,
    input  logic                                       pause,
    input  logic [NUM_CH*SPEED_W-1:0]                  speed,
    output logic [NUM_CH*DIST_W-1:0]                   distance,
    output logic [NUM_CH-1:0]                          finished,
    output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] leader,
`ifdef RACE_PROGRESS_CP_EN
    output logic [NUM_CH-1:0]                          checkpoint,
`endif
    output logic [1:0]                                 race_state
);

    localparam int ACC_W  = DIST_W + FRAC_BITS;
    localparam int LEAD_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    // One extra sum bit means even the largest speed cannot wrap before
    // the saturation comparison sees it.
    localparam logic [ACC_W:0]   SAT_SUM = (ACC_W+1)'(TRACK_LEN) << FRAC_BITS;
    localparam logic [ACC_W-1:0] SAT_ACC = SAT_SUM[ACC_W-1:0];

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        RACING   = 2'b01,
        FINISHED = 2'b10
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [ACC_W-1:0]    acc_q  [NUM_CH];
    logic [ACC_W:0]      sum    [NUM_CH];
    logic [DIST_W-1:0]   dist_q [NUM_CH];
    logic [NUM_CH-1:0]   fin_q;
    logic [LEAD_W-1:0]   lead_q;
    logic [LEAD_W-1:0]   lead_d;
    logic [DIST_W-1:0]   best_dist;
    logic                accumulate;

    // Race state register
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: start from idle, finish when the player finishes, restart from finished
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (race_start) state_d = RACING;
            RACING:   if (!race_start && fin_q[0]) state_d = FINISHED;
            FINISHED: if (race_start) state_d = RACING;
            default:  state_d = IDLE;
        endcase
    end

    // Frame-step qualifier and per-channel candidate sums; race_start masks the frame
    always_comb begin
        accumulate = (state_q != IDLE) && startOfFrame && !pause && !race_start;
        for (int i = 0; i < NUM_CH; i++) begin
            sum[i] = {1'b0, acc_q[i]} + (ACC_W+1)'(speed[i*SPEED_W +: SPEED_W]);
        end
    end

    // Fixed-point accumulators with saturation at the finish line and sticky finish flags
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < NUM_CH; i++) begin
                acc_q[i] <= '0;
            end
            fin_q <= '0;
        end else if (race_start) begin
            for (int i = 0; i < NUM_CH; i++) begin
                acc_q[i] <= '0;
            end
            fin_q <= '0;
        end else if (accumulate) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (!fin_q[i]) begin
                    if (sum[i] >= SAT_SUM) begin
                        acc_q[i] <= SAT_ACC;
                        fin_q[i] <= 1'b1;
                    end else begin
                        acc_q[i] <= sum[i][ACC_W-1:0];
                    end
                end
            end
        end
    end

    // Registered integer distance, one clock behind the accumulator
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < NUM_CH; i++) begin
                dist_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                dist_q[i] <= race_start ? '0 : acc_q[i][ACC_W-1:FRAC_BITS];
            end
        end
    end

    // Leader search over registered distances; strict compare keeps the lowest index on ties
    always_comb begin
        lead_d    = '0;
        best_dist = dist_q[0];
        for (int i = 1; i < NUM_CH; i++) begin
            if (dist_q[i] > best_dist) begin
                best_dist = dist_q[i];
                lead_d    = LEAD_W'(i);
            end
        end
    end

    // Leader register, one clock behind distance
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            lead_q <= '0;
        end else begin
            lead_q <= lead_d;
        end
    end

`ifdef RACE_PROGRESS_CP_EN
    localparam logic [31:0] CP_DIV = 32'(CP_STEP);

    logic [NUM_CH-1:0] cp_hit;
    logic [NUM_CH-1:0] cp_q;

    // A checkpoint is crossed when the incoming distance lands in a higher CP_STEP bucket
    always_comb begin
        cp_hit = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cp_hit[i] = (32'(acc_q[i][ACC_W-1:FRAC_BITS]) / CP_DIV) >
                        (32'(dist_q[i]) / CP_DIV);
        end
    end

    // Checkpoint pulse register, aligned with the distance update
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            cp_q <= '0;
        end else if (race_start) begin
            cp_q <= '0;
        end else begin
            cp_q <= cp_hit;
        end
    end

    assign checkpoint = cp_q;
`endif

    // Output packing
    always_comb begin
        distance = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            distance[i*DIST_W +: DIST_W] = dist_q[i];
        end
    end

    assign finished   = fin_q;
    assign leader     = lead_q;
    assign race_state = state_q;

endmodule
